// File: rtl/rvfi_commit_sequencer.sv
// rvfi_commit_sequencer
// Merges the retirement streams of two commit lanes into one strictly
// in-order RVFI commit stream. Each lane is buffered in a small circular
// FIFO; one record per cycle is released in ascending order sequence.
// Duplicate heads, stale heads and a stall timeout are latched as faults.
module rvfi_commit_sequencer #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 311,
    parameter int TIMEOUT   = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             in_valid,
    output logic [1:0]             in_ready,
    input  logic [127:0]           in_order,
    input  logic [2*PAYLOAD_W-1:0] in_payload,
    output logic                   out_valid,
    output logic [63:0]            out_order,
    output logic [PAYLOAD_W-1:0]   out_payload,
    output logic                   error,
    output logic [1:0]             err_code
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_ERROR = 1'b1
    } state_t;

    state_t state_reg, state_next;

    logic [1:0]                  full;
    logic [1:0]                  empty;
    logic [1:0]                  push;
    logic [1:0]                  pop;
    logic [1:0][63:0]            head_order;
    logic [1:0][PAYLOAD_W-1:0]   head_payload;

    logic [63:0]                 next_order_reg;
    logic [SW-1:0]               stall_reg;

    logic                        out_valid_reg;
    logic [63:0]                 out_order_reg;
    logic [PAYLOAD_W-1:0]        out_payload_reg;
    logic [1:0]                  err_code_reg;

    // Selection results
    logic [1:0]                  match;
    logic [1:0]                  older;
    logic                        dup_fault;
    logic                        stale_fault;
    logic                        timeout_fault;
    logic                        any_fault;
    logic                        rel_fire;
    logic                        sel_lane;
    logic [1:0]                  fault_code;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [63:0]          order_mem   [DEPTH];
            logic [PAYLOAD_W-1:0] payload_mem [DEPTH];
            logic [AW:0]          wr_ptr_reg;
            logic [AW:0]          rd_ptr_reg;

            // Extra pointer bit distinguishes full from empty
            assign full[gi]  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                               (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
            assign empty[gi] = (wr_ptr_reg == rd_ptr_reg);

            // A full FIFO refuses even when popped this cycle
            assign in_ready[gi] = !full[gi] && (state_reg == ST_RUN) && !rst;
            assign push[gi]     = in_valid[gi] && in_ready[gi];

            assign head_order[gi]   = order_mem[rd_ptr_reg[AW-1:0]];
            assign head_payload[gi] = payload_mem[rd_ptr_reg[AW-1:0]];

            // Pointer update; push and pop may both happen in one cycle
            always_ff @(posedge clk) begin
                if (rst) begin
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                end else begin
                    if (push[gi]) wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + 1'b1;
                end
            end

            // Storage write; contents need no reset since pointers gate use
            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    order_mem[wr_ptr_reg[AW-1:0]]   <= in_order[64*gi +: 64];
                    payload_mem[wr_ptr_reg[AW-1:0]] <= in_payload[PAYLOAD_W*gi +: PAYLOAD_W];
                end
            end
        end
    endgenerate

    // Head comparison, fault detection and release selection
    always_comb begin
        match         = 2'b00;
        older         = 2'b00;
        dup_fault     = 1'b0;
        stale_fault   = 1'b0;
        timeout_fault = 1'b0;
        rel_fire      = 1'b0;
        sel_lane      = 1'b0;
        pop           = 2'b00;
        fault_code    = 2'b00;
        for (int i = 0; i < 2; i++) begin
            match[i] = !empty[i] && (head_order[i] == next_order_reg);
            older[i] = !empty[i] && (head_order[i] <  next_order_reg);
        end
        if (state_reg == ST_RUN) begin
            dup_fault   = &match;
            stale_fault = (|older) && !dup_fault;
            // A stale head blocks release even if the other head matches
            rel_fire    = (match[0] ^ match[1]) && !stale_fault;
            sel_lane    = match[1];
            // Counter is about to reach TIMEOUT on this edge
            timeout_fault = !rel_fire && !(&empty) &&
                            (stall_reg == SW'(TIMEOUT - 1));
            if (rel_fire) pop = match;
        end
        any_fault = dup_fault || stale_fault || timeout_fault;
        if (dup_fault)          fault_code = 2'b01;
        else if (stale_fault)   fault_code = 2'b10;
        else if (timeout_fault) fault_code = 2'b11;
    end

    // Two-state control: RUN until the first fault, then hold ERROR
    always_comb begin
        state_next = state_reg;
        if (state_reg == ST_RUN && any_fault) state_next = ST_ERROR;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_RUN;
        else     state_reg <= state_next;
    end

    // Expected order counter, wraps naturally at 2^64
    always_ff @(posedge clk) begin
        if (rst)           next_order_reg <= '0;
        else if (rel_fire) next_order_reg <= next_order_reg + 64'd1;
    end

    // Stall counter: frozen in ERROR, saturates at TIMEOUT
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_reg <= '0;
        end else if (state_reg == ST_RUN) begin
            if (rel_fire || (&empty))
                stall_reg <= '0;
            else if (stall_reg != SW'(TIMEOUT))
                stall_reg <= stall_reg + 1'b1;
        end
    end

    // Registered release outputs; data holds when nothing is released
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg   <= 1'b0;
            out_order_reg   <= '0;
            out_payload_reg <= '0;
        end else begin
            out_valid_reg <= rel_fire;
            if (rel_fire) begin
                out_order_reg   <= head_order[sel_lane];
                out_payload_reg <= head_payload[sel_lane];
            end
        end
    end

    // First fault cause; later faults cannot occur once in ERROR
    always_ff @(posedge clk) begin
        if (rst)            err_code_reg <= 2'b00;
        else if (any_fault) err_code_reg <= fault_code;
    end

    assign out_valid   = out_valid_reg;
    assign out_order   = out_order_reg;
    assign out_payload = out_payload_reg;
    assign err_code    = err_code_reg;
    assign error       = (state_reg == ST_ERROR);

endmodule

// File: tb/tb_rvfi_commit_sequencer.sv
// Directed testbench for rvfi_commit_sequencer (TIMEOUT overridden to 8).
module tb_rvfi_commit_sequencer;

    localparam int PW = 311;

    logic          clk;
    logic          rst;
    logic [1:0]    in_valid;
    logic [1:0]    in_ready;
    logic [127:0]  in_order;
    logic [2*PW-1:0] in_payload;
    logic          out_valid;
    logic [63:0]   out_order;
    logic [PW-1:0] out_payload;
    logic          error;
    logic [1:0]    err_code;

    int checks;
    int failures;

    rvfi_commit_sequencer #(
        .DEPTH(4),
        .PAYLOAD_W(PW),
        .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_order(in_order),
        .in_payload(in_payload),
        .out_valid(out_valid),
        .out_order(out_order),
        .out_payload(out_payload),
        .error(error),
        .err_code(err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Payload is a fixed function of the order so releases can be checked
    function automatic logic [PW-1:0] pay(input logic [63:0] o);
        logic [PW-1:0] r;
        r = '0;
        r[63:0]    = o;
        r[127:64]  = o ^ 64'hDEADBEEF_CAFEF00D;
        r[191:128] = o * 64'd7;
        r[310:300] = 11'h5A5;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1);
        in_valid   = v;
        in_order   = {o1, o0};
        in_payload = {pay(o1), pay(o0)};
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive(2'b00, 64'd0, 64'd0);
        tick;
        tick;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(2'b00, 64'd0, 64'd0);
        tick;
        tick;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_order !== 64'd0) begin failures++; $display("FAIL reset_out_order got=%0h exp=0", out_order); end
        checks++; if (out_payload !== '0) begin failures++; $display("FAIL reset_out_payload got=%0h exp=0", out_payload); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got=%b exp=0", error); end
        checks++; if (err_code !== 2'b00) begin failures++; $display("FAIL reset_err_code got=%b exp=00", err_code); end
        checks++; if (in_ready !== 2'b00) begin failures++; $display("FAIL reset_in_ready got=%b exp=00", in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 2'b11) begin failures++; $display("FAIL post_reset_in_ready got=%b exp=11", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid); end
        $display("reset: in_ready=%b error=%b", in_ready, error);
    endtask

    task automatic test_lane0_seq;
        logic [63:0] exp_o;
        int first;
        do_reset;
        exp_o = 0;
        first = -1;
        for (int c = 0; c < 14; c++) begin
            if (c < 10) drive(2'b01, 64'(c), 64'd0);
            else        drive(2'b00, 64'd0, 64'd0);
            tick;
            if (out_valid) begin
                if (first < 0) first = c;
                $display("lane0_seq: release order=%0d", out_order);
                checks++;
                if (out_order !== exp_o || out_payload !== pay(exp_o)) begin
                    failures++; $display("FAIL lane0_order got=%0d exp=%0d", out_order, exp_o);
                end
                exp_o++;
            end else if (first >= 0 && exp_o < 10) begin
                checks++; failures++; $display("FAIL lane0_gap got=0 exp=1 at order %0d", exp_o);
            end
        end
        checks++; if (first !== 1) begin failures++; $display("FAIL lane0_latency got=%0d exp=1", first); end
        checks++; if (exp_o !== 64'd10) begin failures++; $display("FAIL lane0_count got=%0d exp=10", exp_o); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL lane0_error got=%b exp=0", error); end
    endtask

    task automatic test_alternate;
        logic [63:0] n0, n1, exp_o;
        logic [1:0]  acc;
        bit saw_block;
        bit started;
        do_reset;
        n0 = 0; n1 = 1; exp_o = 0; saw_block = 0; started = 0;
        for (int c = 0; c < 60; c++) begin
            drive({n1 < 20, n0 < 20}, n0, n1);
            acc = in_valid & in_ready;
            if (in_ready !== 2'b11) saw_block = 1;
            tick;
            if (acc[0]) n0 += 2;
            if (acc[1]) n1 += 2;
            if (out_valid) begin
                started = 1;
                $display("alternate: release order=%0d", out_order);
                checks++;
                if (out_order !== exp_o || out_payload !== pay(exp_o)) begin
                    failures++; $display("FAIL alt_order got=%0d exp=%0d", out_order, exp_o);
                end
                exp_o++;
            end else if (started && exp_o < 20) begin
                checks++; failures++; $display("FAIL alt_gap got=0 exp=1 at order %0d", exp_o);
            end
        end
        drive(2'b00, 64'd0, 64'd0);
        checks++; if (exp_o !== 64'd20) begin failures++; $display("FAIL alt_count got=%0d exp=20", exp_o); end
        checks++; if (saw_block !== 1'b1) begin failures++; $display("FAIL alt_backpressure got=0 exp=1"); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL alt_error got=%b exp=0", error); end
    endtask

    task automatic test_early_lane1;
        do_reset;
        drive(2'b10, 64'd0, 64'd1);
        tick;
        drive(2'b00, 64'd0, 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL early_hold got=%b exp=0", out_valid); end
        end
        drive(2'b01, 64'd0, 64'd0);
        tick;
        drive(2'b00, 64'd0, 64'd0);
        tick;
        $display("early: valid=%b order=%0d", out_valid, out_order);
        checks++; if (out_valid !== 1'b1 || out_order !== 64'd0) begin failures++; $display("FAIL early_first got=%b/%0d exp=1/0", out_valid, out_order); end
        tick;
        $display("early: valid=%b order=%0d", out_valid, out_order);
        checks++; if (out_valid !== 1'b1 || out_order !== 64'd1 || out_payload !== pay(64'd1)) begin failures++; $display("FAIL early_second got=%b/%0d exp=1/1", out_valid, out_order); end
        tick;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL early_done got=%b exp=0", out_valid); end
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL early_error got=%b exp=0", error); end
    endtask

    task automatic test_duplicate;
        do_reset;
        drive(2'b11, 64'd0, 64'd0);
        tick;
        drive(2'b00, 64'd0, 64'd0);
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL dup_early_error got=%b exp=0", error); end
        tick;
        $display("duplicate: error=%b err_code=%b", error, err_code);
        checks++; if (error !== 1'b1) begin failures++; $display("FAIL dup_error got=%b exp=1", error); end
        checks++; if (err_code !== 2'b01) begin failures++; $display("FAIL dup_code got=%b exp=01", err_code); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL dup_no_release got=%b exp=0", out_valid); end
        tick;
        checks++; if (in_ready !== 2'b00) begin failures++; $display("FAIL dup_in_ready got=%b exp=00", in_ready); end
    endtask

    task automatic test_stale;
        logic [63:0] exp_o;
        do_reset;
        exp_o = 0;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) drive(2'b01, 64'(c), 64'd0);
            else       drive(2'b00, 64'd0, 64'd0);
            tick;
            if (out_valid) begin
                $display("stale: release order=%0d", out_order);
                checks++;
                if (out_order !== exp_o) begin failures++; $display("FAIL stale_pre_order got=%0d exp=%0d", out_order, exp_o); end
                exp_o++;
            end
        end
        checks++; if (exp_o !== 64'd3) begin failures++; $display("FAIL stale_pre_count got=%0d exp=3", exp_o); end
        drive(2'b01, 64'd1, 64'd0);
        tick;
        drive(2'b00, 64'd0, 64'd0);
        checks++; if (error !== 1'b0) begin failures++; $display("FAIL stale_early_error got=%b exp=0", error); end
        tick;
        $display("stale: error=%b err_code=%b", error, err_code);
        checks++; if (error !== 1'b1 || err_code !== 2'b10) begin failures++; $display("FAIL stale_code got=%b/%b exp=1/10", error, err_code); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stale_no_release got=%b exp=0", out_valid); end
        tick; tick; tick;
        checks++; if (error !== 1'b1 || err_code !== 2'b10) begin failures++; $display("FAIL stale_sticky got=%b/%b exp=1/10", error, err_code); end
        rst = 1'b1;
        tick;
        checks++; if (error !== 1'b0 || err_code !== 2'b00) begin failures++; $display("FAIL stale_rst_error got=%b/%b exp=0/00", error, err_code); end
        checks++; if (out_valid !== 1'b0 || out_order !== 64'd0 || out_payload !== '0) begin failures++; $display("FAIL stale_rst_out got=%b/%0d exp=0/0", out_valid, out_order); end
        checks++; if (in_ready !== 2'b00) begin failures++; $display("FAIL stale_rst_in_ready got=%b exp=00", in_ready); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 2'b11) begin failures++; $display("FAIL stale_post_in_ready got=%b exp=11", in_ready); end
    endtask

    task automatic test_timeout;
        do_reset;
        drive(2'b01, 64'd5, 64'd0);
        tick;
        drive(2'b00, 64'd0, 64'd0);
        for (int i = 1; i <= 7; i++) begin
            tick;
            checks++; if (error !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL timeout_early cyc=%0d got=%b exp=0", i, error); end
        end
        tick;
        $display("timeout: error=%b err_code=%b", error, err_code);
        checks++; if (error !== 1'b1 || err_code !== 2'b11) begin failures++; $display("FAIL timeout_code got=%b/%b exp=1/11", error, err_code); end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 2'b11 || error !== 1'b0) begin failures++; $display("FAIL timeout_rst got=%b/%b exp=11/0", in_ready, error); end
        drive(2'b01, 64'd0, 64'd0);
        tick;
        drive(2'b00, 64'd0, 64'd0);
        tick;
        $display("timeout: post-reset release valid=%b order=%0d", out_valid, out_order);
        checks++; if (out_valid !== 1'b1 || out_order !== 64'd0) begin failures++; $display("FAIL timeout_next_order got=%b/%0d exp=1/0", out_valid, out_order); end
        tick;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL timeout_discard got=%b exp=0", out_valid); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(2'b00, 64'd0, 64'd0);
        test_reset;
        test_lane0_seq;
        test_alternate;
        test_early_lane1;
        test_duplicate;
        test_stale;
        test_timeout;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
